// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: shadows the E/M/W destination/source fields and drives
// stall, flush, forwarding and redirect controls, with variable-latency load support.
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              is_load_d,
    input  logic              pcsrc_e,
    input  logic              mem_ready,
    input  logic              cnt_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              redirect_en,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic              mem_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              wr_e, ld_e, wr_m, ld_m, wr_w;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait, load_use;

    // x0 is hardwired, so it never produces a dependency.
    function automatic logic writes_reg(input logic [REG_AW-1:0] rd, input logic wr,
                                        input logic [REG_AW-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    assign mem_wait = ld_m && !mem_ready;
    assign load_use = ld_e && (writes_reg(rd_e, wr_e, rs1_d) || writes_reg(rd_e, wr_e, rs2_d));

    // A pending memory wait freezes everything; a taken branch makes the D-stage consumer
    // wrong-path, so it overrides the load-use stall.
    assign stall_f     = mem_wait || (load_use && !pcsrc_e);
    assign stall_d     = stall_f;
    assign stall_e     = mem_wait;
    assign stall_m     = mem_wait;
    assign flush_d     = pcsrc_e && !mem_wait;
    assign flush_e     = (pcsrc_e || load_use) && !mem_wait;
    assign flush_w     = mem_wait;
    assign redirect_en = pcsrc_e && !mem_wait;

    always_comb begin
        // NOTE: outputs get a default before the if/else chain so no path leaves them unassigned (no latch).
        forward_ae = 2'b00;
        forward_be = 2'b00;
        // A load in M has no data yet; its consumer picks it up from W a cycle later.
        if (writes_reg(rd_m, wr_m, rs1_e) && !ld_m)
            forward_ae = 2'b10;
        else if (writes_reg(rd_w, wr_w, rs1_e))
            forward_ae = 2'b01;
        if (writes_reg(rd_m, wr_m, rs2_e) && !ld_m)
            forward_be = 2'b10;
        else if (writes_reg(rd_w, wr_w, rs2_e))
            forward_be = 2'b01;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_e <= '0; rs2_e <= '0; rd_e <= '0; wr_e <= 1'b0; ld_e <= 1'b0;
            rd_m  <= '0; wr_m  <= 1'b0; ld_m <= 1'b0;
            rd_w  <= '0; wr_w  <= 1'b0;
        end else if (mem_wait) begin
            rd_w <= '0;
            wr_w <= 1'b0;
        end else begin
            if (flush_e) begin
                rs1_e <= '0; rs2_e <= '0; rd_e <= '0; wr_e <= 1'b0; ld_e <= 1'b0;
            end else begin
                rs1_e <= rs1_d; rs2_e <= rs2_d; rd_e <= rd_d;
                wr_e  <= regwrite_d; ld_e <= is_load_d;
            end
            rd_m <= rd_e; wr_m <= wr_e; ld_m <= ld_e;
            rd_w <= rd_m; wr_w <= wr_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_en && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

    // The wait counter saturates at TIMEOUT; the flag latches on the edge where the
    // TIMEOUT-th consecutive wait cycle completes and is only advisory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (!mem_wait)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (cnt_clr)
                mem_timeout <= 1'b0;
            else if (mem_wait && (wait_cnt >= WAIT_LAST))
                mem_timeout <= 1'b1;
        end
    end

endmodule
